// File: rtl/rgb_pwm_fader.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pwm_fader
// Brief    : Multi-channel PWM LED driver with jump/fade level transitions.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_pwm_fader #(
    parameter int CHANNELS   = 3,
    parameter int WIDTH      = 8,
    parameter int FADE_DIV   = 4,
    parameter bit ACTIVE_LOW = 1'b1,
    localparam int c_chan_w  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [c_chan_w-1:0] cfg_chan,
    input  logic [WIDTH-1:0]    cfg_level,
    input  logic                cfg_fade,
    output logic [CHANNELS-1:0] led,
    output logic [CHANNELS-1:0] busy,
    output logic                period_tick
);

    localparam int              c_fdiv_w    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [WIDTH-1:0] c_cnt_last = WIDTH'((1 << WIDTH) - 2);
    localparam logic [c_fdiv_w-1:0] c_fdiv_last = c_fdiv_w'(FADE_DIV - 1);

    logic [WIDTH-1:0]    r_cnt;
    logic [c_fdiv_w-1:0] r_fdiv;
    logic [CHANNELS-1:0] r_led;
    logic [CHANNELS-1:0] w_on;
    logic                w_boundary;
    logic                w_step;
    logic                w_xfer;

    assign w_boundary  = (r_cnt == c_cnt_last);
    assign w_step      = w_boundary && (r_fdiv == c_fdiv_last);
    // Ready drops on boundaries so a write never races a level update.
    assign cfg_ready   = rst && !w_boundary;
    assign w_xfer      = cfg_valid && cfg_ready;
    assign period_tick = w_boundary;
    assign led         = r_led;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_fdiv <= '0;
        end else begin
            r_cnt <= w_boundary ? '0 : r_cnt + 1'b1;
            if (w_boundary) begin
                r_fdiv <= (r_fdiv == c_fdiv_last) ? '0 : r_fdiv + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [WIDTH-1:0] r_cur;
        logic [WIDTH-1:0] r_tgt;
        logic             r_mode;
        logic             w_sel;

        // Out-of-range channel numbers match no instance and are dropped.
        assign w_sel   = w_xfer && (cfg_chan == c_chan_w'(i));
        assign w_on[i] = (r_cnt < r_cur);
        assign busy[i] = (r_cur != r_tgt);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_cur  <= '0;
                r_tgt  <= '0;
                r_mode <= 1'b0;
            end else if (w_sel) begin
                r_tgt  <= cfg_level;
                r_mode <= cfg_fade;
            end else if (w_boundary && (r_cur != r_tgt)) begin
                if (!r_mode) begin
                    r_cur <= r_tgt;
                end else if (w_step) begin
                    r_cur <= (r_cur < r_tgt) ? r_cur + 1'b1 : r_cur - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led <= {CHANNELS{ACTIVE_LOW}};
        end else begin
            r_led <= w_on ^ {CHANNELS{ACTIVE_LOW}};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rgb_pwm_fader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_pwm_fader
// Brief    : Directed, scoreboard-checked bench for rgb_pwm_fader (W=4, C=3, FD=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_pwm_fader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_chan = '0;
    logic [3:0] cfg_level = '0;
    logic       cfg_fade = 1'b0;
    logic [2:0] led;
    logic [2:0] busy;
    logic       period_tick;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [2:0] led;
        logic [2:0] busy;
        logic       ready;
        logic       tick;
    } exp_t;

    exp_t q[$];

    // Reference model state (value after the most recent posedge)
    int   mcnt;
    int   mfdiv;
    int   mcur [3];
    int   mtgt [3];
    logic mmode [3];
    logic [2:0] mled;
    logic last_xfer;
    int   low_cnt [3];
    int   tick_cnt;

    rgb_pwm_fader #(
        .CHANNELS  (3),
        .WIDTH     (4),
        .FADE_DIV  (2),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_level  (cfg_level),
        .cfg_fade   (cfg_fade),
        .led        (led),
        .busy       (busy),
        .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mcnt = 0; mfdiv = 0; mled = 3'b111; last_xfer = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mcur[i] = 0; mtgt[i] = 0; mmode[i] = 1'b0;
        end
        q.delete();
    endtask

    task automatic clr_counts();
        tick_cnt = 0;
        for (int i = 0; i < 3; i++) low_cnt[i] = 0;
    endtask

    // One clock: advance the model at posedge, push expectation, compare at negedge.
    task automatic cyc();
        exp_t e;
        logic bnd, step, xfer;
        @(posedge clk);
        bnd  = (mcnt == 14);
        step = bnd && (mfdiv == 1);
        xfer = cfg_valid && !bnd;
        for (int i = 0; i < 3; i++) mled[i] = !(mcnt < mcur[i]);
        for (int i = 0; i < 3; i++) begin
            if (bnd && mcur[i] != mtgt[i]) begin
                if (!mmode[i]) mcur[i] = mtgt[i];
                else if (step) mcur[i] = (mcur[i] < mtgt[i]) ? mcur[i] + 1 : mcur[i] - 1;
            end
        end
        if (xfer && cfg_chan < 3) begin
            mtgt[cfg_chan]  = int'(cfg_level);
            mmode[cfg_chan] = cfg_fade;
        end
        if (bnd) mfdiv = (mfdiv + 1) % 2;
        mcnt = bnd ? 0 : mcnt + 1;
        last_xfer = xfer;
        e.led   = mled;
        for (int i = 0; i < 3; i++) e.busy[i] = (mcur[i] != mtgt[i]);
        e.ready = (mcnt != 14);
        e.tick  = (mcnt == 14);
        q.push_back(e);
        @(negedge clk);
        e = q.pop_front();
        chk("led", 32'(led), 32'(e.led));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("cfg_ready", 32'(cfg_ready), 32'(e.ready));
        chk("period_tick", 32'(period_tick), 32'(e.tick));
        if (period_tick) tick_cnt++;
        for (int i = 0; i < 3; i++) if (!led[i]) low_cnt[i]++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    // Advance until the current cycle has cnt == target.
    task automatic align(input int target);
        int guard = 0;
        while (mcnt != target && guard < 20) begin
            cyc();
            guard++;
        end
        chk("align_timeout", 32'(mcnt), 32'(target));
    endtask

    task automatic wr(input logic [1:0] ch, input logic [3:0] lvl, input logic fade);
        int guard = 0;
        cfg_valid = 1'b1; cfg_chan = ch; cfg_level = lvl; cfg_fade = fade;
        last_xfer = 1'b0;
        while (!last_xfer && guard < 20) begin
            cyc();
            guard++;
        end
        chk("write_timeout", 32'(last_xfer), 32'd1);
        cfg_valid = 1'b0;
    endtask

    // Count led low cycles over one aligned period, one period after the level settled.
    task automatic duty(input int ch, input int exp_low, input string tag);
        align(0);
        run(15);
        clr_counts();
        run(15);
        chk(tag, 32'(low_cnt[ch]), 32'(exp_low));
    endtask

    initial begin
        model_reset();
        clr_counts();
        // 1. reset and idle
        repeat (2) @(posedge clk);
        #2;
        chk("rst_led", 32'(led), 32'h7);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(cfg_ready), 32'h0);
        chk("rst_tick", 32'(period_tick), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        run(60);
        chk("idle_ticks", 32'(tick_cnt), 32'd4);
        chk("idle_led_low", 32'(low_cnt[0] + low_cnt[1] + low_cnt[2]), 32'd0);

        // 2. jump ch0 to 5 mid-period
        align(6);
        wr(2'd0, 4'd5, 1'b0);
        chk("jump_busy", 32'(busy[0]), 32'd1);
        duty(0, 5, "duty_ch0_5");

        // 3. ch2 full on then off
        wr(2'd2, 4'd15, 1'b0);
        duty(2, 15, "duty_ch2_15");
        wr(2'd2, 4'd0, 1'b0);
        duty(2, 0, "duty_ch2_0");

        // 4. fade ch1 0->3, then 3->1
        wr(2'd1, 4'd3, 1'b1);
        run(15 * 8);
        chk("fade_up_done", 32'(busy[1]), 32'd0);
        duty(1, 3, "duty_ch1_3");
        wr(2'd1, 4'd1, 1'b1);
        run(15 * 3);
        chk("fade_down_busy", 32'(busy[1]), 32'd1);
        run(15 * 3);
        chk("fade_down_done", 32'(busy[1]), 32'd0);
        duty(1, 1, "duty_ch1_1");

        // 5. handshake across boundary, back-to-back, out-of-range channel
        align(14);
        wr(2'd2, 4'd7, 1'b0);
        wr(2'd0, 4'd4, 1'b0);
        wr(2'd0, 4'd9, 1'b0);
        duty(0, 9, "duty_ch0_9");
        wr(2'd3, 4'd12, 1'b0);
        run(20);
        chk("bad_chan_busy", 32'(busy), 32'h0);
        duty(2, 7, "duty_ch2_7");

        // 6. async reset mid-fade
        wr(2'd1, 4'd15, 1'b1);
        run(40);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_led", 32'(led), 32'h7);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_ready", 32'(cfg_ready), 32'h0);
        chk("arst_tick", 32'(period_tick), 32'h0);
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        clr_counts();
        run(30);
        chk("post_rst_ticks", 32'(tick_cnt), 32'd2);
        chk("post_rst_low", 32'(low_cnt[0] + low_cnt[1] + low_cnt[2]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rgb_pwm_fader.md
# rgb_pwm_fader

Parametrised multi-channel LED driver. Each channel gets an N-bit brightness level rendered as PWM on an active-low (or active-high) LED pin. A level change either jumps on the next PWM period boundary or fades one step at a time. Sits between control logic and the board LED pins, replacing fixed on/off LED drive.

## Interface

Parameters:

- CHANNELS, 3: number of LED channels (≥1)
- WIDTH, 8: brightness resolution; PWM period P = 2^WIDTH − 1 cycles
- FADE_DIV, 4: PWM periods per fade step (≥1)
- ACTIVE_LOW, 1: 1 means the LED is on when the pin is low

Ports:

- clk  in  1  sole clock
- rst  in  1  asynchronous, active-low reset
- cfg_valid  in  1  write request
- cfg_ready  out  1  write can be accepted
- cfg_chan  in  max(1,$clog2(CHANNELS))  target channel
- cfg_level  in  WIDTH  new target brightness
- cfg_fade  in  1  1 = fade to target, 0 = jump to target
- led  out  CHANNELS  registered LED pins
- busy  out  CHANNELS  channel current level ≠ target
- period_tick  out  1  high in the last cycle of each PWM period

## Operation

- PWM counter `cnt` (WIDTH bits) counts 0..P−1 and wraps; "boundary" = the cycle with cnt == P−1.
- Per channel state:
  - `cur`: displayed level
  - `tgt`: target level
  - `mode`: fade/jump
- Channel on when cnt < cur:
  - cur = 0 → never on
  - cur = 2^WIDTH−1 → always on
- led[i] is registered: led[i] <= on ^ ACTIVE_LOW.
- Write handshake:
  - transfer = cfg_valid && cfg_ready
  - on transfer: tgt[cfg_chan] <= cfg_level, mode[cfg_chan] <= cfg_fade
  - cfg_chan ≥ CHANNELS: transfer completes, no state changes
  - cfg_ready = 0 in boundary cycles and while in reset, 1 otherwise
  - writes therefore never coincide with cur updates
- Fade divider `fdiv` counts boundaries 0..FADE_DIV−1 and wraps. A "step boundary" is a boundary with fdiv == FADE_DIV−1.
- At each boundary, per channel with cur ≠ tgt:
  - jump mode: cur <= tgt
  - fade mode, step boundary: cur <= cur ± 1 toward tgt
  - fade mode, other boundary: hold
- Per-channel state, derived: IDLE (cur == tgt), FADING (mode = 1, cur ≠ tgt), PENDING (mode = 0, cur ≠ tgt).
  - IDLE → FADING/PENDING on a write with a differing level
  - PENDING → IDLE at the next boundary
  - FADING → IDLE at the step boundary where cur reaches tgt
  - A new write mid-fade retargets; cur continues from its present value.
- Level arithmetic is unsigned WIDTH-bit; fade never overshoots or wraps.
- busy[i] = (cur[i] ≠ tgt[i]), combinational from registers.

## Timing

- Reset (rst low, async) clears cnt, fdiv, cur, tgt and mode to 0. During reset:
  - led = {CHANNELS{ACTIVE_LOW}} (all off)
  - busy = 0
  - cfg_ready = 0
  - period_tick = 0
- After reset release:
  - cnt = 0 on the first clock
  - cfg_ready = 1
  - first boundary at cycle P−1
- cur changes only at boundaries. The new cur affects the on-compare from cnt = 0, and led one cycle later (registered).
- Write accepted in period k:
  - jump: effective from period k+1
  - fade: first step at the next step boundary
- Full fade from a to b takes |a−b| step boundaries, i.e. up to |a−b|·FADE_DIV periods.
- period_tick is asserted exactly once per P cycles.
- Reset asserted mid-fade: outputs go to reset values immediately, without waiting for a clock.

## Test plan

Config for all scenarios: WIDTH=4 (P=15), CHANNELS=3, FADE_DIV=2, ACTIVE_LOW=1.

1. Reset, then idle 60 cycles -> led = 3'b111 throughout; busy = 0; cfg_ready = 1 except every 15th cycle; period_tick pulses at cycles 14, 29, 44, 59.
2. Jump ch0 to 5 mid-period -> busy[0] high until the boundary. Each later period: led[0] = 0 for exactly 5 of 15 cycles, starting one cycle after cnt = 0.
3. Jump ch2 to 15, then to 0 -> led[2] constant 0 over a full period, then constant 1.
4. Fade ch1 0→3 -> duty 1/15, 2/15, 3/15, each step 2 periods apart; busy[1] falls at the step boundary reaching 3. Fade 3→1 steps 3, 2, 1 with no overshoot.
5. Handshake -> cfg_valid held across a boundary is accepted the following cycle. Two back-to-back writes to ch0 (4 then 9): 9 wins. cfg_chan = 3 is accepted with no state change.
6. rst low mid-fade, asynchronously between edges -> led = 3'b111 and busy = 0 before the next clk edge. After release, cnt restarts at 0 and all levels read 0.
